// File: rtl/ultrasonic_scheduler_if.sv
// Link between the scheduler and the HC-SR04 controller.
// Valid/ready: start_o is a one-cycle request; done_i is a one-cycle completion qualifying echo_count_i.
interface ultrasonic_scheduler_if #(
  parameter int COUNT_W = 32
);
  logic               start_o;
  logic               done_i;
  logic [COUNT_W-1:0] echo_count_i;

  modport master (
    output start_o,
    input  done_i,
    input  echo_count_i
  );

  modport slave (
    input  start_o,
    output done_i,
    output echo_count_i
  );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Periodic measurement sequencer for the ultrasonic controller: echo timeout supervision,
// batch averaging, hysteresis level flag and sensor-fault flag.
module ultrasonic_scheduler #(
  parameter int COUNT_W        = 32,
  parameter int PERIOD_CYCLES  = 3_000_000,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int AVG_LOG2       = 2,
  parameter int TH_LOW         = 30000,
  parameter int TH_HIGH        = 33000,
  parameter int FAULT_LIMIT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  ultrasonic_scheduler_if.master ctrl,
  output logic [COUNT_W-1:0]    avg_count_o,
  output logic                  avg_valid_o,
  output logic                  level_ok_o,
  output logic                  sensor_fault_o,
  output logic                  busy_o,
  output logic [1:0]            state_dbg_o
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam int ACC_W = COUNT_W + AVG_LOG2;
  localparam int SW    = AVG_LOG2 + 1;
  localparam int FW    = $clog2(FAULT_LIMIT + 1);

  localparam logic [CNT_W-1:0]   PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]      SAMPLE_LAST  = SW'((1 << AVG_LOG2) - 1);
  localparam logic [FW-1:0]      FAULT_C      = FW'(FAULT_LIMIT);
  localparam logic [COUNT_W-1:0] TH_LOW_C     = COUNT_W'(TH_LOW);
  localparam logic [COUNT_W-1:0] TH_HIGH_C    = COUNT_W'(TH_HIGH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ECHO = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [SW-1:0]      sample_cnt;
  logic [FW-1:0]      consec;

  logic               accept, timeout, batch_done;
  logic [ACC_W-1:0]   sum;
  logic [COUNT_W-1:0] avg_next;
  logic [FW-1:0]      consec_next;

  assign state_dbg_o = state;

  // One counter serves as both period and timeout counter: both restart at START.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE:      if (enable_i) next_state = START;
      START:     next_state = WAIT_ECHO;
      WAIT_ECHO: begin
        if (ctrl.done_i) begin
          accept     = 1'b1;
          next_state = GAP;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout    = 1'b1;
          next_state = GAP;
        end
      end
      GAP:       if (cnt == PERIOD_LAST) next_state = enable_i ? START : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    sum         = acc + ACC_W'(ctrl.echo_count_i);
    avg_next    = sum[ACC_W-1:AVG_LOG2];
    batch_done  = accept && (sample_cnt == SAMPLE_LAST);
    consec_next = (consec == FAULT_C) ? consec : consec + FW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ctrl.start_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state        <= next_state;
      ctrl.start_o <= (next_state == START);
      busy_o       <= (next_state != IDLE);
      if (next_state == START)     cnt <= '0;
      else if (next_state != IDLE) cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc            <= '0;
      sample_cnt     <= '0;
      consec         <= '0;
      avg_count_o    <= '0;
      avg_valid_o    <= 1'b0;
      level_ok_o     <= 1'b0;
      sensor_fault_o <= 1'b0;
    end else begin
      avg_valid_o <= 1'b0;
      if (accept) begin
        consec         <= '0;
        sensor_fault_o <= 1'b0;
        if (batch_done) begin
          acc         <= '0;
          sample_cnt  <= '0;
          avg_count_o <= avg_next;
          avg_valid_o <= 1'b1;
          if (avg_next < TH_LOW_C)        level_ok_o <= 1'b1;
          else if (avg_next >= TH_HIGH_C) level_ok_o <= 1'b0;
        end else begin
          acc        <= sum;
          sample_cnt <= sample_cnt + SW'(1);
        end
      end else if (timeout) begin
        // A lost echo poisons the batch, so the partial sum is dropped.
        acc        <= '0;
        sample_cnt <= '0;
        consec     <= consec_next;
        if (consec_next == FAULT_C) begin
          sensor_fault_o <= 1'b1;
          level_ok_o     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Self-checking bench for ultrasonic_scheduler: batch table, timeout/fault, enable drop, async reset.
module tb_ultrasonic_scheduler;
  localparam int COUNT_W = 32;
  localparam int EW      = COUNT_W + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [COUNT_W-1:0] avg_count;
  logic               avg_valid;
  logic               level_ok;
  logic               sensor_fault;
  logic               busy;
  logic [1:0]         state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = -1;

  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [3:0][COUNT_W-1:0] c;
    logic [COUNT_W-1:0]      avg;
    logic                    level;
  } vec_t;

  vec_t vecs[7];

  ultrasonic_scheduler_if #(.COUNT_W(COUNT_W)) ctrl();

  ultrasonic_scheduler #(
    .COUNT_W(COUNT_W), .PERIOD_CYCLES(100), .TIMEOUT_CYCLES(60), .AVG_LOG2(2),
    .TH_LOW(30000), .TH_HIGH(33000), .FAULT_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .ctrl(ctrl),
    .avg_count_o(avg_count), .avg_valid_o(avg_valid), .level_ok_o(level_ok),
    .sensor_fault_o(sensor_fault), .busy_o(busy), .state_dbg_o(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // scoreboard: each avg_valid pulse pops one {level, avg} entry
  always @(negedge clk) begin
    if (avg_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_avg actual=%0d expected=none", avg_count);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("sb_avg", avg_count, e[COUNT_W-1:0]);
        check("sb_level", level_ok, e[EW-1]);
      end
    end
  end

  // driver tasks
  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (ctrl.start_o === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL start_wait actual=none expected=start_o within 300 cycles");
    end else begin
      if (last_start >= 0) check("start_period", cyc - last_start, 100);
      last_start = cyc;
    end
  endtask

  task automatic pulse_done(input logic [COUNT_W-1:0] cnt);
    ctrl.echo_count_i = cnt;
    ctrl.done_i = 1'b1;
    @(negedge clk);
    ctrl.done_i = 1'b0;
    ctrl.echo_count_i = $urandom_range(0, 65535);
  endtask

  // give=0 leaves the echo unanswered so the measurement times out
  task automatic measure(input int k, input logic [COUNT_W-1:0] cnt, input bit give,
                         input bit push, input logic [EW-1:0] exp);
    wait_start();
    if (give) begin
      repeat (k) @(negedge clk);
      if (push) exp_q.push_back(exp);
      pulse_done(cnt);
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int starts;
    vecs[0] = '{c: {32'd4000, 32'd3000, 32'd2000, 32'd1000}, avg: 32'd2500, level: 1'b1};
    vecs[1] = '{c: {4{32'd31000}}, avg: 32'd31000, level: 1'b1};
    vecs[2] = '{c: {4{32'd34000}}, avg: 32'd34000, level: 1'b0};
    vecs[3] = '{c: {4{32'd31000}}, avg: 32'd31000, level: 1'b0};
    vecs[4] = '{c: {4{32'd29999}}, avg: 32'd29999, level: 1'b1};
    vecs[5] = '{c: {4{32'd33000}}, avg: 32'd33000, level: 1'b0};
    vecs[6] = '{c: {32'd2, 32'd1, 32'd1, 32'd1}, avg: 32'd1, level: 1'b1};

    rst = 1'b1;
    enable = 1'b0;
    ctrl.done_i = 1'b0;
    ctrl.echo_count_i = '0;
    repeat (3) @(negedge clk);
    check("rst_start", ctrl.start_o, 0);
    check("rst_avg", avg_count, 0);
    check("rst_valid", avg_valid, 0);
    check("rst_level", level_ok, 0);
    check("rst_fault", sensor_fault, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_enable", busy, 0);
    enable = 1'b1;

    // periodic batches and hysteresis
    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < 4; j++)
        measure(20, vecs[v].c[j], 1'b1, j == 3, {vecs[v].level, vecs[v].avg});
      check("avg_valid_latency", avg_valid, 1);
      check("avg_value", avg_count, vecs[v].avg);
      check("level_value", level_ok, vecs[v].level);
      @(negedge clk);
      check("avg_valid_pulse", avg_valid, 0);
    end

    // timeout/fault with a partial batch
    measure(20, 32'd100, 1'b1, 1'b0, '0);
    measure(20, 32'd100, 1'b1, 1'b0, '0);
    measure(0, '0, 1'b0, 1'b0, '0);
    measure(0, '0, 1'b0, 1'b0, '0);
    wait_start();
    repeat (59) @(negedge clk);
    check("fault_before_limit", sensor_fault, 0);
    check("level_before_fault", level_ok, 1);
    @(negedge clk);
    check("fault_raised", sensor_fault, 1);
    check("fault_level_low", level_ok, 0);
    measure(20, 32'd20000, 1'b1, 1'b0, '0);
    check("fault_cleared", sensor_fault, 0);
    check("level_held_after_fault", level_ok, 0);
    measure(20, 32'd20000, 1'b1, 1'b0, '0);
    measure(20, 32'd20000, 1'b1, 1'b0, '0);
    measure(20, 32'd20000, 1'b1, 1'b1, {1'b1, 32'd20000});

    // done on the timeout cycle wins over the timeout
    measure(0, '0, 1'b0, 1'b0, '0);
    measure(0, '0, 1'b0, 1'b0, '0);
    measure(59, 32'd8000, 1'b1, 1'b0, '0);
    check("done_at_timeout_no_fault", sensor_fault, 0);
    measure(20, 32'd8000, 1'b1, 1'b0, '0);
    measure(20, 32'd8000, 1'b1, 1'b0, '0);
    measure(20, 32'd8000, 1'b1, 1'b1, {1'b1, 32'd8000});

    // enable drop during WAIT_ECHO
    for (int j = 0; j < 3; j++) measure(20, 32'd5000, 1'b1, 1'b0, '0);
    wait_start();
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (15) @(negedge clk);
    exp_q.push_back({1'b1, 32'd5000});
    pulse_done(32'd5000);
    check("disable_done_accepted", avg_valid, 1);
    repeat (78) @(negedge clk);
    check("busy_in_gap", busy, 1);
    @(negedge clk);
    check("busy_fall", busy, 0);
    check("state_idle", state_dbg, 0);
    starts = 0;
    repeat (150) begin
      @(negedge clk);
      if (ctrl.start_o === 1'b1) starts++;
    end
    check("no_start_disabled", starts, 0);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_start", ctrl.start_o, 1);
    last_start = cyc;

    // async reset mid-WAIT_ECHO with 3 samples held
    repeat (20) @(negedge clk);
    pulse_done(32'd7000);
    measure(20, 32'd7000, 1'b1, 1'b0, '0);
    measure(20, 32'd7000, 1'b1, 1'b0, '0);
    wait_start();
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_start", ctrl.start_o, 0);
    check("arst_avg", avg_count, 0);
    check("arst_valid", avg_valid, 0);
    check("arst_level", level_ok, 0);
    check("arst_fault", sensor_fault, 0);
    check("arst_busy", busy, 0);
    check("arst_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    last_start = -1;
    for (int j = 0; j < 4; j++) measure(20, 32'd9000, 1'b1, j == 3, {1'b1, 32'd9000});
    repeat (3) @(negedge clk);
    check("post_reset_level", level_ok, 1);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
